// File: rtl/thread_scheduler.sv
// Per-thread IDLE/RUN/STALL run-state tracker for the barrel core, turning the
// current round-robin slot into a registered fetch-or-bubble issue decision.
module thread_scheduler #(
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = 2,
    parameter int STALL_W     = 4,
    parameter int BUBBLE_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TID_W-1:0]       thread_timer_data,
    input  logic                   start_valid,
    input  logic [TID_W-1:0]       start_tid,
    input  logic                   halt_valid,
    input  logic [TID_W-1:0]       halt_tid,
    input  logic                   stall_valid,
    input  logic [TID_W-1:0]       stall_tid,
    input  logic [STALL_W-1:0]     stall_cycles,
    output logic                   issue_valid,
    output logic [TID_W-1:0]       issue_tid,
    output logic [NUM_THREADS-1:0] active_mask,
    output logic [NUM_THREADS-1:0] stalled_mask,
    output logic                   all_idle,
    output logic [BUBBLE_W-1:0]    bubble_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_e;

    state_e                 state_q [NUM_THREADS];
    state_e                 state_d [NUM_THREADS];
    logic [STALL_W-1:0]     cnt_q   [NUM_THREADS];
    logic [STALL_W-1:0]     cnt_d   [NUM_THREADS];
    logic [NUM_THREADS-1:0] active_q, active_d;
    logic [NUM_THREADS-1:0] stalled_q, stalled_d;
    logic                   all_idle_q;
    logic                   issue_valid_q, issue_valid_d;
    logic [TID_W-1:0]       issue_tid_q;
    logic [BUBBLE_W-1:0]    bubble_q, bubble_d;
    logic [NUM_THREADS-1:0] start_hit_s, halt_hit_s, stall_hit_s;
    logic [STALL_W-1:0]     stall_load_s;

    assign start_hit_s  = start_valid ? (NUM_THREADS'(1) << start_tid) : '0;
    assign halt_hit_s   = halt_valid  ? (NUM_THREADS'(1) << halt_tid)  : '0;
    assign stall_hit_s  = stall_valid ? (NUM_THREADS'(1) << stall_tid) : '0;
    // A zero-length stall still costs the thread one slot opportunity.
    assign stall_load_s = (stall_cycles == '0) ? STALL_W'(1) : stall_cycles;

    // Next run state and stall counter per thread; halt beats stall beats start.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            state_d[t] = state_q[t];
            cnt_d[t]   = cnt_q[t];
            case (state_q[t])
                ST_IDLE: begin
                    if (start_hit_s[t] && !halt_hit_s[t]) begin
                        state_d[t] = ST_RUN;
                    end else begin
                        state_d[t] = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (halt_hit_s[t]) begin
                        state_d[t] = ST_IDLE;
                        cnt_d[t]   = '0;
                    end else if (stall_hit_s[t]) begin
                        state_d[t] = ST_STALL;
                        cnt_d[t]   = stall_load_s;
                    end else begin
                        state_d[t] = ST_RUN;
                    end
                end
                ST_STALL: begin
                    if (halt_hit_s[t]) begin
                        state_d[t] = ST_IDLE;
                        cnt_d[t]   = '0;
                    end else if (cnt_q[t] <= STALL_W'(1)) begin
                        state_d[t] = ST_RUN;
                        cnt_d[t]   = '0;
                    end else begin
                        cnt_d[t]   = cnt_q[t] - STALL_W'(1);
                    end
                end
                default: begin
                    state_d[t] = ST_IDLE;
                    cnt_d[t]   = '0;
                end
            endcase
            active_d[t]  = (state_d[t] != ST_IDLE);
            stalled_d[t] = (state_d[t] == ST_STALL);
        end
    end

    // Issue decision for the current slot and saturating bubble accounting.
    always_comb begin
        issue_valid_d = (state_q[thread_timer_data] == ST_RUN)
                        && !halt_hit_s[thread_timer_data]
                        && !stall_hit_s[thread_timer_data];
        if (!issue_valid_d && (active_q != '0) && (bubble_q != '1)) begin
            bubble_d = bubble_q + BUBBLE_W'(1);
        end else begin
            bubble_d = bubble_q;
        end
    end

    // State, counters and every output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                state_q[t] <= ST_IDLE;
                cnt_q[t]   <= '0;
            end
            active_q      <= '0;
            stalled_q     <= '0;
            all_idle_q    <= 1'b1;
            issue_valid_q <= 1'b0;
            issue_tid_q   <= '0;
            bubble_q      <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                state_q[t] <= state_d[t];
                cnt_q[t]   <= cnt_d[t];
            end
            active_q      <= active_d;
            stalled_q     <= stalled_d;
            all_idle_q    <= (active_d == '0);
            issue_valid_q <= issue_valid_d;
            issue_tid_q   <= thread_timer_data;
            bubble_q      <= bubble_d;
        end
    end

    assign issue_valid  = issue_valid_q;
    assign issue_tid    = issue_tid_q;
    assign active_mask  = active_q;
    assign stalled_mask = stalled_q;
    assign all_idle     = all_idle_q;
    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_thread_scheduler.sv
// Scenario-driven bench for thread_scheduler with a thread-level reference model;
// a second instance with a 4-bit bubble counter exposes saturation.
module tb_thread_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  thread_timer_data;
    logic        start_valid, halt_valid, stall_valid;
    logic [1:0]  start_tid, halt_tid, stall_tid;
    logic [3:0]  stall_cycles;

    logic        issue_valid, s_issue_valid, all_idle, s_all_idle;
    logic [1:0]  issue_tid, s_issue_tid;
    logic [3:0]  active_mask, stalled_mask, s_active_mask, s_stalled_mask;
    logic [15:0] bubble_count;
    logic [3:0]  s_bubble_count;

    int tests  = 0;
    int failed = 0;

    // Reference model: 0 = IDLE, 1 = RUN, 2 = STALL; m_left = stall cycles remaining.
    int m_state [4];
    int m_left  [4];
    int m_bubble;
    bit m_valid;
    int m_tid;

    thread_scheduler dut (
        .clk(clk), .rst(rst), .thread_timer_data(thread_timer_data),
        .start_valid(start_valid), .start_tid(start_tid),
        .halt_valid(halt_valid), .halt_tid(halt_tid),
        .stall_valid(stall_valid), .stall_tid(stall_tid), .stall_cycles(stall_cycles),
        .issue_valid(issue_valid), .issue_tid(issue_tid),
        .active_mask(active_mask), .stalled_mask(stalled_mask),
        .all_idle(all_idle), .bubble_count(bubble_count)
    );

    thread_scheduler #(.BUBBLE_W(4)) dut_s (
        .clk(clk), .rst(rst), .thread_timer_data(thread_timer_data),
        .start_valid(start_valid), .start_tid(start_tid),
        .halt_valid(halt_valid), .halt_tid(halt_tid),
        .stall_valid(stall_valid), .stall_tid(stall_tid), .stall_cycles(stall_cycles),
        .issue_valid(s_issue_valid), .issue_tid(s_issue_tid),
        .active_mask(s_active_mask), .stalled_mask(s_stalled_mask),
        .all_idle(s_all_idle), .bubble_count(s_bubble_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int t = 0; t < 4; t++) begin
            m_state[t] = 0;
            m_left[t]  = 0;
        end
        m_bubble = 0;
        m_valid  = 1'b0;
        m_tid    = 0;
    endtask

    task automatic model_edge();
        int  s;
        bit  any_active;
        s = int'(thread_timer_data);
        any_active = 1'b0;
        for (int t = 0; t < 4; t++) if (m_state[t] != 0) any_active = 1'b1;
        m_valid = (m_state[s] == 1) && !(halt_valid && int'(halt_tid) == s)
                  && !(stall_valid && int'(stall_tid) == s);
        m_tid = s;
        if (!m_valid && any_active) m_bubble++;
        for (int t = 0; t < 4; t++) begin
            if (halt_valid && int'(halt_tid) == t) begin
                m_state[t] = 0;
                m_left[t]  = 0;
            end else if (m_state[t] == 1 && stall_valid && int'(stall_tid) == t) begin
                m_state[t] = 2;
                m_left[t]  = (stall_cycles == 4'd0) ? 1 : int'(stall_cycles);
            end else if (m_state[t] == 2) begin
                m_left[t]--;
                if (m_left[t] == 0) m_state[t] = 1;
            end else if (m_state[t] == 0 && start_valid && int'(start_tid) == t) begin
                m_state[t] = 1;
            end
        end
    endtask

    function automatic logic [11:0] exp_vec();
        logic [3:0] act, stl;
        for (int t = 0; t < 4; t++) begin
            act[t] = (m_state[t] != 0);
            stl[t] = (m_state[t] == 2);
        end
        return {m_valid, 2'(m_tid), act, stl, (act == 4'd0)};
    endfunction

    task automatic clear_events();
        start_valid = 1'b0; halt_valid = 1'b0; stall_valid = 1'b0;
        start_tid = 2'd0; halt_tid = 2'd0; stall_tid = 2'd0; stall_cycles = 4'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        clear_events();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        thread_timer_data = 2'd0;
        clear_events();
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({issue_valid, issue_tid, active_mask, stalled_mask, all_idle, bubble_count} !==
            {1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 16'd0}) begin
            failed++;
            $display("FAIL reset_values: got v=%0b tid=%0d act=%b stl=%b idle=%0b bub=%0d, want 0 0 0000 0000 1 0",
                     issue_valid, issue_tid, active_mask, stalled_mask, all_idle, bubble_count);
        end
        for (int i = 0; i < 8; i++) begin
            thread_timer_data = 2'(i);
            tick();
            tests++;
            if (issue_valid !== 1'b0 || all_idle !== 1'b1 || bubble_count !== 16'd0) begin
                failed++;
                $display("FAIL reset_idle_run cyc %0d: got v=%0b idle=%0b bub=%0d, want 0 1 0",
                         i, issue_valid, all_idle, bubble_count);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            thread_timer_data = 2'(k + 3);
            start_valid = 1'b1;
            start_tid   = 2'(k);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            thread_timer_data = 2'(i + 3);
            tick();
            tests++;
            if (issue_valid !== 1'b1 || issue_tid !== 2'(i + 3) || active_mask !== 4'b1111) begin
                failed++;
                $display("FAIL round_robin cyc %0d: got v=%0b tid=%0d act=%b, want 1 %0d 1111",
                         i, issue_valid, issue_tid, active_mask, 2'(i + 3));
            end
        end
        tests++;
        if (bubble_count !== 16'd0) begin
            failed++;
            $display("FAIL round_robin_bubbles: got %0d want 0", bubble_count);
        end
    endtask

    task automatic test_stall();
        logic exp_stl [4];
        exp_stl = '{1'b1, 1'b1, 1'b1, 1'b0};
        thread_timer_data = 2'd2;
        stall_valid  = 1'b1;
        stall_tid    = 2'd2;
        stall_cycles = 4'd3;
        tick();
        tests++;
        if (issue_valid !== 1'b0) begin
            failed++;
            $display("FAIL stall_slot_issue: got %0b want 0", issue_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (stalled_mask[2] !== exp_stl[i]) begin
                failed++;
                $display("FAIL stall_mask cyc %0d: got %0b want %0b", i, stalled_mask[2], exp_stl[i]);
            end
            thread_timer_data = 2'(i + 3);
            tick();
        end
        tests++;
        if (issue_valid !== 1'b1 || issue_tid !== 2'd2 || bubble_count !== 16'd1) begin
            failed++;
            $display("FAIL stall_reissue: got v=%0b tid=%0d bub=%0d, want 1 2 1",
                     issue_valid, issue_tid, bubble_count);
        end
    endtask

    task automatic test_priority();
        thread_timer_data = 2'd1;
        halt_valid = 1'b1; halt_tid = 2'd1;
        stall_valid = 1'b1; stall_tid = 2'd1; stall_cycles = 4'd5;
        start_valid = 1'b1; start_tid = 2'd1;
        tick();
        tests++;
        if (issue_valid !== 1'b0 || active_mask[1] !== 1'b0 || stalled_mask[1] !== 1'b0) begin
            failed++;
            $display("FAIL priority_halt: got v=%0b act1=%0b stl1=%0b, want 0 0 0",
                     issue_valid, active_mask[1], stalled_mask[1]);
        end
        for (int i = 0; i < 4; i++) begin
            thread_timer_data = 2'(i + 2);
            tick();
            tests++;
            if ({issue_valid, issue_tid, active_mask, stalled_mask, all_idle} !== exp_vec()) begin
                failed++;
                $display("FAIL priority_after cyc %0d: got %b want %b", i,
                         {issue_valid, issue_tid, active_mask, stalled_mask, all_idle}, exp_vec());
            end
        end
    endtask

    task automatic test_single_thread();
        do_reset();
        thread_timer_data = 2'd3;
        start_valid = 1'b1; start_tid = 2'd0;
        tick();
        for (int i = 0; i < 8; i++) begin
            thread_timer_data = 2'(i);
            tick();
            tests++;
            if (issue_valid !== (2'(i) == 2'd0)) begin
                failed++;
                $display("FAIL single_thread cyc %0d: got v=%0b want %0b", i, issue_valid, 2'(i) == 2'd0);
            end
        end
        tests++;
        if (bubble_count !== 16'd6) begin
            failed++;
            $display("FAIL single_thread_bubbles: got %0d want 6", bubble_count);
        end
    endtask

    task automatic test_async_reset();
        logic exp_stl [4];
        exp_stl = '{1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        thread_timer_data = 2'd3;
        start_valid = 1'b1; start_tid = 2'd0;
        tick();
        thread_timer_data = 2'd0;
        stall_valid = 1'b1; stall_tid = 2'd0; stall_cycles = 4'd0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (stalled_mask[0] !== exp_stl[i]) begin
                failed++;
                $display("FAIL zero_stall cyc %0d: got %0b want %0b", i, stalled_mask[0], exp_stl[i]);
            end
            thread_timer_data = 2'(i + 1);
            tick();
        end
        tests++;
        if (issue_valid !== 1'b1 || issue_tid !== 2'd0) begin
            failed++;
            $display("FAIL zero_stall_reissue: got v=%0b tid=%0d want 1 0", issue_valid, issue_tid);
        end
        thread_timer_data = 2'd0;
        stall_valid = 1'b1; stall_tid = 2'd0; stall_cycles = 4'd9;
        tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        tests++;
        if ({issue_valid, issue_tid, active_mask, stalled_mask, all_idle, bubble_count} !==
            {1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 16'd0}) begin
            failed++;
            $display("FAIL async_reset_clear: got v=%0b tid=%0d act=%b stl=%b idle=%0b bub=%0d",
                     issue_valid, issue_tid, active_mask, stalled_mask, all_idle, bubble_count);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            thread_timer_data = 2'd0;
            tick();
            tests++;
            if (issue_valid !== 1'b0 || all_idle !== 1'b1) begin
                failed++;
                $display("FAIL async_reset_leak cyc %0d: got v=%0b idle=%0b want 0 1", i, issue_valid, all_idle);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            thread_timer_data = 2'($urandom_range(0, 3));
            start_valid  = ($urandom_range(0, 2) == 0);
            start_tid    = 2'($urandom_range(0, 3));
            halt_valid   = ($urandom_range(0, 7) == 0);
            halt_tid     = 2'($urandom_range(0, 3));
            stall_valid  = ($urandom_range(0, 3) == 0);
            stall_tid    = 2'($urandom_range(0, 3));
            stall_cycles = 4'($urandom_range(0, 15));
            tick();
            tests++;
            if ({issue_valid, issue_tid, active_mask, stalled_mask, all_idle} !== exp_vec()
                || bubble_count !== 16'(m_bubble)) begin
                failed++;
                $display("FAIL random cyc %0d: got %b bub=%0d want %b bub=%0d", i,
                         {issue_valid, issue_tid, active_mask, stalled_mask, all_idle},
                         bubble_count, exp_vec(), m_bubble);
            end
            tests++;
            if ({s_issue_valid, s_issue_tid, s_active_mask, s_stalled_mask, s_all_idle} !== exp_vec()
                || s_bubble_count !== 4'((m_bubble > 15) ? 15 : m_bubble)) begin
                failed++;
                $display("FAIL random_sat cyc %0d: got %b bub=%0d want %b bub=%0d", i,
                         {s_issue_valid, s_issue_tid, s_active_mask, s_stalled_mask, s_all_idle},
                         s_bubble_count, exp_vec(), (m_bubble > 15) ? 15 : m_bubble);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stall();
        test_priority();
        test_single_thread();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
